// File: rtl/ss_display_scheduler.sv
// ss_display_scheduler
//   Shares one four-digit seven-segment display between three BCD value
//   sources. One owner is shown at a time; owners rotate round-robin after a
//   dwell period, a blank gap separates owners, and source 0 (alert) pre-empts
//   any other owner.
//
// Ports
//   Clk                     system clock, rising edge
//   Reset                   synchronous, active-high
//   Req[2:0]                per-source display request, Req[0] is the alert
//   Lock                    freezes dwell-expiry rotation (not pre-emption)
//   Value0/1/2[15:0]        source digits {BCD3,BCD2,BCD1,BCD0}
//   Grant[2:0]              one-hot current owner, 000 while blanked
//   Ack[2:0]                one-cycle pulse on the owner's bit at grant start
//   BCD3..BCD0[3:0]         digits of the current owner (held while blank)
//   Blank                   high when no source is shown
module ss_display_scheduler #(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int BLANK_CYCLES = 1_000_000,
  parameter int CNT_W        = 27
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  Req,
  input  logic        Lock,
  input  logic [15:0] Value0,
  input  logic [15:0] Value1,
  input  logic [15:0] Value2,
  output logic [2:0]  Grant,
  output logic [2:0]  Ack,
  output logic [3:0]  BCD3,
  output logic [3:0]  BCD2,
  output logic [3:0]  BCD1,
  output logic [3:0]  BCD0,
  output logic        Blank
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       owner, owner_nxt;
  logic [1:0]       last_owner, last_owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       grant_nxt, ack_nxt;
  logic [15:0]      bcd, bcd_nxt;
  logic             blank_nxt;
  logic             others_req;

  // First requesting index after 'last' in the cyclic order 0->1->2->0.
  // Only meaningful when at least one request is high.
  function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                         input logic [2:0] req);
    logic [1:0] o0, o1, o2;
    case (last)
      2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (req[o0])      rr_pick = o0;
    else if (req[o1]) rr_pick = o1;
    else              rr_pick = o2;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    onehot = 3'b001 << idx;
  endfunction

  function automatic logic [15:0] src_value(input logic [1:0]  idx,
                                            input logic [15:0] v0,
                                            input logic [15:0] v1,
                                            input logic [15:0] v2);
    case (idx)
      2'd0:    src_value = v0;
      2'd1:    src_value = v1;
      default: src_value = v2;
    endcase
  endfunction

  assign others_req = |(Req & ~onehot(owner));

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    cnt_nxt        = cnt;
    grant_nxt      = 3'b000;
    ack_nxt        = 3'b000;
    bcd_nxt        = bcd;
    blank_nxt      = 1'b1;

    case (state)
      IDLE: begin
        // No gap when leaving IDLE: the pick is shown on the next edge.
        if (|Req) begin
          state_nxt = SHOW;
          owner_nxt = rr_pick(last_owner, Req);
          cnt_nxt   = '0;
        end
      end
      SHOW: begin
        // Exit checks are ordered; an owner drop wins over everything,
        // including a coincident dwell expiry.
        if (!Req[owner]) begin
          state_nxt = others_req ? GAP : IDLE;
          cnt_nxt   = '0;
        end else if (Req[0] && owner != 2'd0) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else if (cnt == DWELL_LAST && !Lock && owner != 2'd0 && others_req) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else if (cnt == DWELL_LAST) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        // The gap always runs to completion; requests are sampled only here.
        if (cnt == BLANK_LAST) begin
          cnt_nxt = '0;
          if (|Req) begin
            state_nxt = SHOW;
            owner_nxt = Req[0] ? 2'd0 : rr_pick(last_owner, Req);
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (state_nxt == SHOW) begin
      grant_nxt = onehot(owner_nxt);
      blank_nxt = 1'b0;
      bcd_nxt   = src_value(owner_nxt, Value0, Value1, Value2);
      // Ack only on a fresh grant, not on a dwell restart with the same owner.
      if (state != SHOW) begin
        ack_nxt        = onehot(owner_nxt);
        last_owner_nxt = owner_nxt;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd2;
      cnt        <= '0;
      Grant      <= 3'b000;
      Ack        <= 3'b000;
      bcd        <= 16'h0000;
      Blank      <= 1'b1;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      cnt        <= cnt_nxt;
      Grant      <= grant_nxt;
      Ack        <= ack_nxt;
      bcd        <= bcd_nxt;
      Blank      <= blank_nxt;
    end
  end

  assign BCD3 = bcd[15:12];
  assign BCD2 = bcd[11:8];
  assign BCD1 = bcd[7:4];
  assign BCD0 = bcd[3:0];

endmodule

// File: tb/tb_ss_display_scheduler.sv
module tb_ss_display_scheduler;

  logic        Clk;
  logic        Reset;
  logic [2:0]  Req;
  logic        Lock;
  logic [15:0] Value0, Value1, Value2;
  logic [2:0]  Grant, Ack;
  logic [3:0]  BCD3, BCD2, BCD1, BCD0;
  logic        Blank;

  int passed;
  int total;

  logic [2:0]  eg, ea;
  logic [15:0] eb;
  logic [22:0] obs, exp_v;

  ss_display_scheduler #(
    .DWELL_CYCLES(8),
    .BLANK_CYCLES(2),
    .CNT_W(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Lock(Lock),
    .Value0(Value0), .Value1(Value1), .Value2(Value2),
    .Grant(Grant), .Ack(Ack),
    .BCD3(BCD3), .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0),
    .Blank(Blank)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign obs = {Grant, Ack, Blank, BCD3, BCD2, BCD1, BCD0};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    Req   = 3'b000;
    Lock  = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    total++;
    if (obs !== {3'b000, 3'b000, 1'b1, 16'h0000})
      $display("FAIL reset_state got=%h want=%h", obs, {3'b000, 3'b000, 1'b1, 16'h0000});
    else passed++;
    Reset = 1'b0;
    // Reset in the middle of source 1's SHOW.
    Value1 = 16'h1234;
    Req    = 3'b010;
    tick();
    total++;
    if (obs !== {3'b010, 3'b010, 1'b0, 16'h1234})
      $display("FAIL reset_first_grant got=%h want=%h", obs, {3'b010, 3'b010, 1'b0, 16'h1234});
    else passed++;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    total++;
    if (obs !== {3'b000, 3'b000, 1'b1, 16'h0000})
      $display("FAIL reset_mid_show got=%h want=%h", obs, {3'b000, 3'b000, 1'b1, 16'h0000});
    else passed++;
    Reset = 1'b0;
    tick();
    total++;
    if (obs !== {3'b010, 3'b010, 1'b0, 16'h1234})
      $display("FAIL reset_regrant got=%h want=%h", obs, {3'b010, 3'b010, 1'b0, 16'h1234});
    else passed++;
    tick();
    total++;
    if (obs !== {3'b010, 3'b000, 1'b0, 16'h1234})
      $display("FAIL reset_ack_clear got=%h want=%h", obs, {3'b010, 3'b000, 1'b0, 16'h1234});
    else passed++;
  endtask

  task automatic test_rotation();
    apply_reset();
    Value1 = 16'h1234;
    Value2 = 16'h5678;
    Req    = 3'b110;
    for (int i = 1; i <= 21; i++) begin
      tick();
      eg = 3'b000; ea = 3'b000; eb = 16'h1234;
      if (i <= 8)       eg = 3'b010;
      else if (i <= 10) eg = 3'b000;
      else if (i <= 18) begin eg = 3'b100; eb = 16'h5678; end
      else if (i <= 20) eb = 16'h5678;
      else              eg = 3'b010;
      if (i == 1 || i == 11 || i == 21) ea = eg;
      exp_v = {eg, ea, (eg == 3'b000), eb};
      total++;
      if (obs !== exp_v)
        $display("FAIL rotation cyc=%0d got=%h want=%h", i, obs, exp_v);
      else passed++;
    end
  endtask

  task automatic test_lock();
    apply_reset();
    Value1 = 16'h1111;
    Value2 = 16'h2222;
    Req    = 3'b110;
    Lock   = 1'b1;
    for (int i = 1; i <= 51; i++) begin
      tick();
      eg = 3'b000; ea = 3'b000; eb = 16'h1111;
      if (i <= 48)      eg = 3'b010;
      else if (i <= 50) eg = 3'b000;
      else begin eg = 3'b100; eb = 16'h2222; end
      if (i == 1 || i == 51) ea = eg;
      exp_v = {eg, ea, (eg == 3'b000), eb};
      total++;
      if (obs !== exp_v)
        $display("FAIL lock cyc=%0d got=%h want=%h", i, obs, exp_v);
      else passed++;
      if (i == 45) Lock = 1'b0;
    end
  endtask

  task automatic test_preempt();
    apply_reset();
    Value0 = 16'h9876;
    Value2 = 16'h4321;
    Req    = 3'b100;
    for (int i = 1; i <= 26; i++) begin
      tick();
      eg = 3'b000; ea = 3'b000; eb = 16'h4321;
      if (i <= 3)      eg = 3'b100;
      else if (i <= 5) eg = 3'b000;
      else begin eg = 3'b001; eb = 16'h9876; end
      if (i == 1 || i == 6) ea = eg;
      exp_v = {eg, ea, (eg == 3'b000), eb};
      total++;
      if (obs !== exp_v)
        $display("FAIL preempt cyc=%0d got=%h want=%h", i, obs, exp_v);
      else passed++;
      if (i == 3) Req = 3'b101;
    end
  endtask

  task automatic test_drop_idle();
    apply_reset();
    Value1 = 16'h0505;
    Value2 = 16'h0707;
    Req    = 3'b010;
    for (int i = 1; i <= 5; i++) tick();
    Req = 3'b000;
    tick();
    total++;
    if (obs !== {3'b000, 3'b000, 1'b1, 16'h0505})
      $display("FAIL drop_to_idle got=%h want=%h", obs, {3'b000, 3'b000, 1'b1, 16'h0505});
    else passed++;
    Req = 3'b100;
    tick();
    total++;
    if (obs !== {3'b100, 3'b100, 1'b0, 16'h0707})
      $display("FAIL idle_no_gap got=%h want=%h", obs, {3'b100, 3'b100, 1'b0, 16'h0707});
    else passed++;
  endtask

  task automatic test_value_follow();
    apply_reset();
    Value1 = 16'h0001;
    Value2 = 16'h0009;
    Req    = 3'b110;
    for (int i = 1; i <= 11; i++) begin
      tick();
      eg = 3'b000; ea = 3'b000; eb = 16'h0002;
      if (i <= 3)       begin eg = 3'b010; eb = 16'h0001; end
      else if (i <= 8)  eg = 3'b010;
      else if (i <= 10) eg = 3'b000;
      else              begin eg = 3'b100; eb = 16'h0009; end
      if (i == 1 || i == 11) ea = eg;
      exp_v = {eg, ea, (eg == 3'b000), eb};
      total++;
      if (obs !== exp_v)
        $display("FAIL value_follow cyc=%0d got=%h want=%h", i, obs, exp_v);
      else passed++;
      if (i == 3) Value1 = 16'h0002;
      if (i == 9) Value1 = 16'h0003;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    Reset  = 1'b1;
    Req    = 3'b000;
    Lock   = 1'b0;
    Value0 = 16'h0000;
    Value1 = 16'h0000;
    Value2 = 16'h0000;
    test_reset();
    test_rotation();
    test_lock();
    test_preempt();
    test_drop_idle();
    test_value_follow();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ss_display_scheduler.md
# ss_display_scheduler

Shares the four-digit seven-segment display between three BCD value sources. Grants one source at a time, rotates round-robin on a fixed dwell period, inserts a blanking gap between owners, and lets source 0 (alert) pre-empt. Outputs feed the BCD3..BCD0 inputs of the display driver. Blank is ORed with system Reset into the driver's Reset input.

## Interface
- DWELL_CYCLES, 100_000_000: cycles an owner is shown before rotation is considered (1 s at 100 MHz); must be ≥ 2.
- BLANK_CYCLES, 1_000_000: length of the blank gap between owners (10 ms); must be ≥ 1.
- CNT_W, 27: counter width; must hold max(DWELL_CYCLES, BLANK_CYCLES) − 1.

- Clk  in  1  system clock, 100 MHz, all logic on rising edge
- Reset  in  1  synchronous, active-high
- Req  in  3  per-source display request; Req[0] is the alert source
- Lock  in  1  freezes normal rotation while high; does not block alert pre-emption
- Value0, Value1, Value2  in  16 each  source digits {BCD3,BCD2,BCD1,BCD0}, each nibble 0–9
- Grant  out  3  one-hot current owner; 000 when none
- Ack  out  3  one-cycle pulse on the owner's bit in the first SHOW cycle of each grant
- BCD3, BCD2, BCD1, BCD0  out  4 each  digits of the current owner
- Blank  out  1  high when no source is shown

## Operation
- All outputs are registered. Reset values: Grant=000, Ack=000, BCD*=0, Blank=1, state=IDLE, counter=0, last_owner=2 (so the first pick searches from 0).
- Round-robin pick: the first requesting index after last_owner, in the order 0→1→2→0. In SHOW and GAP, an asserted Req[0] overrides the pick and selects 0.
- FSM states: IDLE, SHOW, GAP.
- IDLE:
  - Blank=1, Grant=000.
  - Any Req bit high → SHOW with the picked owner. No gap is inserted from IDLE.
- SHOW:
  - Blank=0, Grant=onehot(owner). The counter counts 0..DWELL_CYCLES−1.
  - BCD* is loaded every cycle from the owner's Value.
  - last_owner is updated to owner on entry.
- SHOW exits, in priority order:
  1. Req[owner]=0: go to GAP if any other Req is high, else IDLE.
  2. Req[0]=1 and owner≠0: go to GAP immediately (pre-emption), regardless of counter or Lock.
  3. counter=DWELL_CYCLES−1, Lock=0, owner≠0, and another Req is high: go to GAP.
  4. counter=DWELL_CYCLES−1 otherwise: reset the counter and stay in SHOW with the same owner, with no Ack pulse.
- Owner 0 is never rotated out while Req[0]=1.
- GAP:
  - Blank=1, Grant=000, BCD* holds its last value. The counter counts 0..BLANK_CYCLES−1.
  - At counter=BLANK_CYCLES−1: pick again. If any Req is high → SHOW with the new pick, else IDLE.
  - Requests that drop or rise during GAP are honoured at GAP exit only.
  - Exception: if all Req bits drop during GAP, the block still waits out the full gap, then goes to IDLE.
- Counter clears on every state change.
- Lock held high with a single requester has no effect.
- Lock rising mid-dwell blocks only the next expiry rotation.
- Values are passed through without range checking. A non-BCD nibble is displayed as presented.

## Timing
- Req[i] high sampled at edge k while in IDLE → after edge k: Grant[i]=1, Ack[i]=1, Blank=0, BCD*=Value_i sampled at edge k. After edge k+1: Ack=000.
- While in SHOW: BCD* after edge n equals the owner's Value sampled at edge n (one-cycle latency).
- An uninterrupted SHOW lasts exactly DWELL_CYCLES cycles. A GAP lasts exactly BLANK_CYCLES cycles.
- Req[owner] falling at edge k → Grant=000 and Blank=1 after edge k.
- Req[0] rising at edge k during another owner's SHOW → GAP after edge k. Owner 0 is shown after edge k+BLANK_CYCLES.
- Reset sampled high at any edge, in any state → reset values after that edge. The first grant is possible at the edge after Reset falls.
- Simultaneous events in one cycle follow the SHOW exit priority list. Dwell expiry coinciding with owner drop is treated as a drop.

## Test plan
Benches use DWELL_CYCLES=8, BLANK_CYCLES=2.
- Reset mid-SHOW of source 1 → next cycle: Grant=000, Blank=1, BCD*=0. After release, Req=010 → Grant=010 one cycle later with Ack=010.
- Req=110, Value1=16'h1234, Value2=16'h5678:
  - Source 1 is shown for 8 cycles with BCD*=1,2,3,4.
  - Then 2 blank cycles.
  - Then source 2 for 8 cycles with BCD*=5,6,7,8.
  - Then back to source 1. Ack pulses at each grant start.
- Req=110 with Lock=1 → source 1 is held indefinitely (at least 40 cycles), with no Ack repeats. Lock dropped → the rotation to source 2 starts at the next dwell expiry.
- Source 2 shown, Req[0] raised at its cycle 3 → Blank on the next cycle, Grant=001 two cycles later. Owner 0 is kept while Req[0]=1 even with Req[2]=1 and Lock=0.
- Req=010, then dropped at SHOW cycle 5 → IDLE with Blank=1 on the next cycle. Req=100 raised during that IDLE → Grant=100 one cycle later with no gap.
- Value1 changes 16'h0001→16'h0002 mid-SHOW → BCD0 follows exactly one cycle later. BCD* is frozen through GAP.
